// File: rtl/pipeline_pkg.sv
// Shared core-wide widths, the NOP encoding and the default fetch-queue entry layout.
package pipeline_pkg;
   localparam int          XLEN      = 32;
   localparam int          ILEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
      logic            misalign;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: synchronous FIFO of fetch entries with flush and occupancy count.
module fetch_fifo
   import pipeline_pkg::*;
#(
   parameter type entry_t = fetch_entry_t,
   parameter int  DEPTH   = 4
)(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush,
   input  logic                   push,
   input  entry_t                 wdata,
   input  logic                   pop,
   output entry_t                 rdata,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   entry_t      mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (!rst_i || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/pipeline_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps up to DEPTH fetches in flight or queued, feeds decode.
// Optional FETCH_MISALIGN_EN: a misaligned redirect halts fetch and delivers one marker entry.
module pipeline_fetch_unit
   import pipeline_pkg::*;
#(
   parameter int              XLEN     = pipeline_pkg::XLEN,
   parameter int              ILEN     = pipeline_pkg::ILEN,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
)(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ready_i,
   input  logic            imem_rvalid_i,
   input  logic [ILEN-1:0] imem_rdata_i,
   output logic            id_valid_o,
   input  logic            id_ready_i,
   output logic [ILEN-1:0] id_instr_o,
   output logic [XLEN-1:0] id_pc_o,
   output logic            id_misalign_o
);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
      logic            misalign;
   } entry_t;

   logic [XLEN-1:0] pc_q, resp_pc_q, target;
   logic [CW-1:0]   outstanding_q, drop_cnt_q, q_count, in_flight_after_redirect;
   logic            halted_q, marker_pend_q, misalign_redirect;
   logic            credit_ok, accept, rsp_keep, marker_push, push, pop, q_empty;
   entry_t          push_entry, head;

`ifdef FETCH_MISALIGN_EN
   assign target            = redirect_pc_i;
   assign misalign_redirect = |redirect_pc_i[1:0];
`else
   assign target            = redirect_pc_i & ~XLEN'(3);
   assign misalign_redirect = 1'b0;
`endif

   // Queued plus in-flight never exceeds DEPTH, so responses always find room.
   assign credit_ok   = ({1'b0, outstanding_q} + {1'b0, q_count}) < (CW+1)'(DEPTH);
   assign imem_req_o  = rst_i && !redirect_i && !halted_q && credit_ok;
   assign imem_addr_o = pc_q;
   assign accept      = imem_req_o && imem_ready_i;

   assign rsp_keep    = imem_rvalid_i && (drop_cnt_q == '0);
   assign marker_push = marker_pend_q && (drop_cnt_q == '0);
   assign push        = !redirect_i && (marker_push || rsp_keep);
   assign pop         = id_valid_o && id_ready_i;
   assign in_flight_after_redirect = outstanding_q - CW'(imem_rvalid_i);

   always_comb begin
      push_entry.pc       = resp_pc_q;
      push_entry.instr    = imem_rdata_i;
      push_entry.misalign = 1'b0;
      if (marker_push) begin
         push_entry.instr    = ILEN'(NOP_INSTR);
         push_entry.misalign = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         pc_q          <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         halted_q      <= 1'b0;
         marker_pend_q <= 1'b0;
      end else if (redirect_i) begin
         pc_q          <= target;
         resp_pc_q     <= target;
         outstanding_q <= in_flight_after_redirect;
         drop_cnt_q    <= in_flight_after_redirect;
         halted_q      <= misalign_redirect;
         marker_pend_q <= misalign_redirect;
      end else begin
         if (accept) pc_q <= pc_q + XLEN'(4);
         outstanding_q <= outstanding_q + CW'(accept) - CW'(imem_rvalid_i);
         if (imem_rvalid_i) begin
            if (drop_cnt_q != '0) drop_cnt_q <= drop_cnt_q - CW'(1);
            else                  resp_pc_q  <= resp_pc_q + XLEN'(4);
         end
         if (marker_push) marker_pend_q <= 1'b0;
      end
   end

   fetch_fifo #(
      .entry_t (entry_t),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .flush (redirect_i),
      .push  (push),
      .wdata (push_entry),
      .pop   (pop),
      .rdata (head),
      .empty (q_empty),
      .count (q_count)
   );

   assign id_valid_o    = rst_i && !q_empty && !redirect_i;
   assign id_instr_o    = head.instr;
   assign id_pc_o       = head.pc;
   assign id_misalign_o = id_valid_o && head.misalign;
endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Bench for pipeline_fetch_unit: in-order variable-latency memory model plus a program-order stream scoreboard.
module tb_pipeline_fetch_unit;
   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk_i = 1'b0;
   logic        rst_i, redirect_i, imem_req_o, imem_ready_i, imem_rvalid_i;
   logic        id_valid_o, id_ready_i, id_misalign_o;
   logic [31:0] redirect_pc_i, imem_addr_o, imem_rdata_i, id_instr_o, id_pc_o;

   pipeline_fetch_unit #(
      .XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_instr_o(id_instr_o),
      .id_pc_o(id_pc_o), .id_misalign_o(id_misalign_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { logic [31:0] addr; int due; } pend_t;
   typedef struct { int lat; logic [31:0] target; logic [31:0] exp_pc; int exp_wait; } vec_t;

   pend_t       pend[$];
   vec_t        vecs[$];
   int          cyc, lat_min, lat_max, ready_pct, inflight, n_acc, pops, marker_pops;
   int          n_tests, n_fail, first, wait_cnt, pops_before;
   logic [31:0] exp_next_pc, exp_req_pc;
   logic        halted_m;
   logic        obs_req, obs_valid;
   logic [31:0] obs_pc, obs_instr;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_EN
      return t;
`else
      return {t[31:2], 2'b00};
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: observe and score at the falling edge, then drive memory after the rising edge.
   task automatic step();
      @(negedge clk_i);
      obs_req   = imem_req_o;
      obs_valid = id_valid_o;
      obs_pc    = id_pc_o;
      obs_instr = id_instr_o;
      if (imem_rvalid_i) inflight--;
      if (halted_m) chk("req_while_halted", imem_req_o, 1'b0);
      if (imem_req_o) begin
         chk("req_addr", imem_addr_o, exp_req_pc);
         if (imem_ready_i) begin
            pend.push_back('{imem_addr_o, cyc + int'($urandom_range(lat_max, lat_min))});
            exp_req_pc += 4;
            inflight++;
            n_acc++;
            chk("credit", inflight <= DEPTH, 1'b1);
         end
      end
      if (redirect_i) begin
         chk("redirect_no_req", imem_req_o, 1'b0);
         chk("redirect_no_valid", id_valid_o, 1'b0);
         exp_next_pc = eff_target(redirect_pc_i);
         exp_req_pc  = exp_next_pc;
`ifdef FETCH_MISALIGN_EN
         halted_m = |redirect_pc_i[1:0];
`endif
      end else if (id_valid_o && id_ready_i) begin
         pops++;
`ifdef FETCH_MISALIGN_EN
         if (halted_m) begin
            chk("marker_pc", id_pc_o, exp_next_pc);
            chk("marker_instr", id_instr_o, NOP);
            chk("marker_flag", id_misalign_o, 1'b1);
            marker_pops++;
         end else
`endif
         begin
            chk("id_pc", id_pc_o, exp_next_pc);
            chk("id_instr", id_instr_o, instr_of(exp_next_pc));
            chk("id_misalign", id_misalign_o, 1'b0);
            exp_next_pc += 4;
         end
      end
      @(posedge clk_i);
      #1;
      cyc++;
      imem_ready_i = ($urandom_range(99) < ready_pct);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = instr_of(pend[0].addr);
         void'(pend.pop_front());
      end else begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = $urandom;
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0; inflight = 0; n_acc = 0; pops = 0; marker_pops = 0;
      exp_next_pc = 32'h0; exp_req_pc = 32'h0; halted_m = 1'b0;
      lat_min = 1; lat_max = 1; ready_pct = 100;
      rst_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
      imem_ready_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; id_ready_i = 1'b0;

      // Redirect table: expected cycles from redirect to first id_valid is latency + 2.
      vecs.push_back('{lat: 1, target: 32'h0000_0100, exp_pc: 32'h0000_0100, exp_wait: 3});
      vecs.push_back('{lat: 2, target: 32'h0000_0040, exp_pc: 32'h0000_0040, exp_wait: 4});
      vecs.push_back('{lat: 3, target: 32'h0000_0100, exp_pc: 32'h0000_0100, exp_wait: 5});
      vecs.push_back('{lat: 1, target: 32'hFFFF_FFF8, exp_pc: 32'hFFFF_FFF8, exp_wait: 3});
      vecs.push_back('{lat: 2, target: 32'h0000_1000, exp_pc: 32'h0000_1000, exp_wait: 4});
`ifndef FETCH_MISALIGN_EN
      vecs.push_back('{lat: 1, target: 32'h0000_0102, exp_pc: 32'h0000_0100, exp_wait: 3});
      vecs.push_back('{lat: 3, target: 32'h0000_020B, exp_pc: 32'h0000_0208, exp_wait: 5});
`endif

      // Reset held three cycles: nothing requested or presented.
      repeat (3) begin
         step();
         chk("rst_req", obs_req, 1'b0);
         chk("rst_valid", obs_valid, 1'b0);
      end

      // Backpressure from release: exactly DEPTH fetches, head pinned at RESET_PC.
      rst_i = 1'b1;
      first = -1;
      for (int c = 0; c < 10; c++) begin
         step();
         if (obs_valid && first < 0) first = c;
         if (obs_valid) chk("bp_head_pc", obs_pc, 32'h0);
      end
      chk("first_valid_cycle", first, 2);
      chk("bp_req_count", n_acc, DEPTH);
      id_ready_i = 1'b1;
      repeat (14) step();
      chk("bp_resume_progress", exp_next_pc >= 32'h20, 1'b1);

      foreach (vecs[i]) begin
         lat_min = vecs[i].lat; lat_max = vecs[i].lat; ready_pct = 100; id_ready_i = 1'b1;
         repeat (8) step();
         redirect_i = 1'b1; redirect_pc_i = vecs[i].target;
         step();
         redirect_i = 1'b0;
         wait_cnt = 0;
         for (int w = 1; w <= 20; w++) begin
            step();
            if (obs_valid) begin
               wait_cnt = w;
               break;
            end
         end
         chk("vec_wait", wait_cnt, vecs[i].exp_wait);
         chk("vec_pc", obs_pc, vecs[i].exp_pc);
         chk("vec_instr", obs_instr, instr_of(vecs[i].exp_pc));
         repeat (4) step();
      end

      // Redirect landing on a response while queued + in-flight is at the DEPTH limit.
      lat_min = 2; lat_max = 2; id_ready_i = 1'b0;
      repeat (10) step();
      redirect_i = 1'b1; redirect_pc_i = 32'h300;
      step();
      redirect_i = 1'b0;
      repeat (4) step();
      chk("full_rvalid_present", imem_rvalid_i, 1'b1);
      redirect_i = 1'b1; redirect_pc_i = 32'h400;
      step();
      redirect_i = 1'b0;
      #1;
      chk("full_flush_empty", id_valid_o, 1'b0);
      id_ready_i = 1'b1;
      repeat (14) step();
      chk("full_resume", exp_next_pc >= 32'h410, 1'b1);

      lat_min = 1; lat_max = 1;
`ifdef FETCH_MISALIGN_EN
      redirect_i = 1'b1; redirect_pc_i = 32'h102;
      step();
      redirect_i = 1'b0;
      repeat (10) step();
      chk("marker_count", marker_pops, 1);
      redirect_i = 1'b1; redirect_pc_i = 32'h200;
      step();
      redirect_i = 1'b0;
      repeat (8) step();
      chk("halt_resume", exp_next_pc >= 32'h204, 1'b1);
`else
      redirect_i = 1'b1; redirect_pc_i = 32'h102;
      step();
      redirect_i = 1'b0;
      obs_valid = 1'b0;
      for (int w = 0; w < 10 && !obs_valid; w++) step();
      chk("misalign_off_pc", obs_pc, 32'h100);
      chk("misalign_off_flag", id_misalign_o, 1'b0);
      repeat (4) step();
`endif

      // Random memory timing, decode stalls and redirects against the stream scoreboard.
      lat_min = 1; lat_max = 4; ready_pct = 70;
      pops_before = pops;
      for (int c = 0; c < 10000; c++) begin
         id_ready_i    = ($urandom_range(99) < 70);
         redirect_i    = ($urandom_range(99) < 2);
         redirect_pc_i = $urandom & 32'hFFFF_FFFC;
         step();
      end
      redirect_i = 1'b0;
      chk("random_progress", (pops - pops_before) > 1000, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
